// File: rtl/cpen391_switch_event_ctrl.sv
// Avalon-MM slider-switch controller: synchroniser, optional debounce, per-bit edge capture, maskable irq.
// Debounce prescaler and two-sample filter are built only when SWITCH_DEBOUNCE_EN is defined.
module cpen391_switch_event_ctrl #(
    parameter int unsigned WIDTH           = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_deb;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_mask;
    logic [1:0]       r_ctrl;
    logic             r_primed;

    logic             w_tick;
    logic [WIDTH-1:0] w_deb_filt;
    logic [WIDTH-1:0] w_deb_next;
    logic [WIDTH-1:0] w_chg;
    logic [WIDTH-1:0] w_edge_set;
    logic [WIDTH-1:0] w_edge_clr;
    logic             w_wr_mask;
    logic             w_wr_edge;
    logic             w_wr_ctrl;
    logic             w_rd;
    logic [31:0]      w_rdata;
    logic             w_unused_wd;

`ifdef SWITCH_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] LP_TICK_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_samp;

    assign w_tick = (r_cnt == LP_TICK_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_samp <= '0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
            if (w_tick) begin
                r_samp <= r_sync;
            end
        end
    end

    // A bit follows sync only when this tick's sample agrees with the previous one.
    assign w_deb_filt = r_deb ^ (~(r_sync ^ r_samp) & (r_sync ^ r_deb));
`else
    logic w_unused_cfg;

    assign w_tick       = 1'b1;
    assign w_deb_filt   = r_sync;
    assign w_unused_cfg = (DEBOUNCE_CYCLES > 1) && (CNT_W > 0);
`endif

    assign w_wr_mask   = chipselect && write && (address == 2'd1);
    assign w_wr_edge   = chipselect && write && (address == 2'd2);
    assign w_wr_ctrl   = chipselect && write && (address == 2'd3);
    assign w_rd        = chipselect && read;
    assign w_unused_wd = ^writedata;

    always_comb begin
        w_deb_next = r_deb;
        w_chg      = '0;
        if (w_tick) begin
            if (!r_primed) begin
                w_deb_next = r_sync;
            end else begin
                w_deb_next = w_deb_filt;
                w_chg      = w_deb_filt ^ r_deb;
            end
        end
        w_edge_set = w_chg & ((w_deb_next & {WIDTH{r_ctrl[0]}}) |
                              (~w_deb_next & {WIDTH{r_ctrl[1]}}));
        w_edge_clr = w_wr_edge ? writedata[WIDTH-1:0] : '0;
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            2'd0:    w_rdata[WIDTH-1:0] = r_deb;
            2'd1:    w_rdata[WIDTH-1:0] = r_mask;
            2'd2:    w_rdata[WIDTH-1:0] = r_edge;
            default: w_rdata[1:0]       = r_ctrl;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta   <= '0;
            r_sync   <= '0;
            r_deb    <= '0;
            r_edge   <= '0;
            r_mask   <= '0;
            r_ctrl   <= 2'b01;
            r_primed <= 1'b0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            r_meta   <= in_port;
            r_sync   <= r_meta;
            r_deb    <= w_deb_next;
            r_primed <= r_primed | w_tick;
            // Set is ORed in after the clear so a coincident event survives.
            r_edge   <= (r_edge & ~w_edge_clr) | w_edge_set;
            if (w_wr_mask) begin
                r_mask <= writedata[WIDTH-1:0];
            end
            if (w_wr_ctrl) begin
                r_ctrl <= writedata[1:0];
            end
            irq      <= |(r_edge & r_mask);
            readdata <= w_rd ? w_rdata : '0;
        end
    end

endmodule

// File: tb/tb_cpen391_switch_event_ctrl.sv
// Bench for cpen391_switch_event_ctrl: cycle-level behavioural model, directed scenarios, randomized traffic.
module tb_cpen391_switch_event_ctrl;

    localparam int W  = 10;
    localparam int D  = 4;
    localparam int CW = 3;
`ifdef SWITCH_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [W-1:0]  in_port = '0;
    logic          irq;

    int n_checks = 0;
    int n_pass   = 0;

    cpen391_switch_event_ctrl #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .read(read),
        .write(write),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: the switch level seen two clocks late, sampled every D cycles,
    // accepted once two consecutive samples agree.
    logic [W-1:0] m_h1, m_h2, m_samp, m_deb, m_edge, m_mask;
    logic [1:0]   m_ctrl;
    bit           m_primed;
    int unsigned  m_k;
    logic [31:0]  m_rd;
    logic         m_irq;

    function automatic logic [31:0] m_reg(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_deb);
            2'd1:    return 32'(m_mask);
            2'd2:    return 32'(m_edge);
            default: return 32'(m_ctrl);
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [W-1:0] nd;
        logic [W-1:0] chg;
        logic [W-1:0] ne;
        bit           tk;
        if (!reset_n) begin
            m_h1 <= '0; m_h2 <= '0; m_samp <= '0; m_deb <= '0;
            m_edge <= '0; m_mask <= '0; m_ctrl <= 2'b01;
            m_primed <= 1'b0; m_k <= 0; m_rd <= '0; m_irq <= 1'b0;
        end else begin
            tk  = DEB_EN ? ((m_k % D) == (D - 1)) : 1'b1;
            nd  = m_deb;
            chg = '0;
            if (tk) begin
                if (!m_primed) begin
                    nd = m_h2;
                    m_primed <= 1'b1;
                end else begin
                    for (int i = 0; i < W; i++) begin
                        if (!DEB_EN || (m_h2[i] == m_samp[i])) nd[i] = m_h2[i];
                    end
                    chg = nd ^ m_deb;
                end
                m_samp <= m_h2;
            end
            ne = m_edge;
            if (chipselect && write && address == 2'd2) ne = ne & ~writedata[W-1:0];
            for (int i = 0; i < W; i++) begin
                if (chg[i] && ((nd[i] && m_ctrl[0]) || (!nd[i] && m_ctrl[1]))) ne[i] = 1'b1;
            end
            m_irq <= |(m_edge & m_mask);
            m_rd  <= (chipselect && read) ? m_reg(address) : 32'd0;
            if (chipselect && write && address == 2'd1) m_mask <= writedata[W-1:0];
            if (chipselect && write && address == 2'd3) m_ctrl <= writedata[1:0];
            m_edge <= ne;
            m_deb  <= nd;
            m_h2   <= m_h1;
            m_h1   <= in_port;
            m_k    <= m_k + 1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            check("readdata", readdata, m_rd);
            check("irq", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0; read = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        logic [31:0] v;
        int          seen;

        // Switches already on across reset
        in_port = '1;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        wait_n(20);
        rd(2'd0, v); check("reset_data", v, 32'h3FF);
        rd(2'd2, v); check("reset_edge", v, DEB_EN ? 32'h0 : 32'h3FF);
        check("reset_irq", {31'd0, irq}, 32'd0);
        rd(2'd3, v); check("reset_ctrl", v, 32'h1);

        in_port = '0;
        do_reset();
        wait_n(20);

        // Rising edge on bit 0 with mask
        wr(2'd1, 32'h1);
        @(negedge clk); in_port[0] = 1'b1;
        wait_n(2 * D + 3);
        rd(2'd2, v); check("rise_edge", v, 32'h1);
        check("rise_irq", {31'd0, irq}, 32'd1);

        // Write-1-to-clear and irq drop two cycles after the strobe
        wr(2'd2, 32'h1);
        check("clr_irq_hold", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("clr_irq", {31'd0, irq}, 32'd0);
        rd(2'd2, v); check("clr_edge", v, 32'h0);

        // Short glitch
        @(negedge clk); in_port[0] = 1'b0;
        wait_n(20);
        rd(2'd0, v); check("pre_glitch_data", v, 32'h0);
        @(negedge clk); in_port[0] = 1'b1;
        wait_n(2);
        in_port[0] = 1'b0;
        wait_n(20);
        rd(2'd0, v); check("glitch_data", v, 32'h0);
        rd(2'd2, v); check("glitch_edge", v, DEB_EN ? 32'h0 : 32'h1);
        check("glitch_irq", {31'd0, irq}, DEB_EN ? 32'd0 : 32'd1);
        wr(2'd2, 32'hFFFF_FFFF);

        // Falling-only capture on bit 3
        wr(2'd3, 32'h2);
        wr(2'd1, 32'h8);
        @(negedge clk); in_port[3] = 1'b1;
        wait_n(20);
        rd(2'd2, v); check("fall_only_rise", v, 32'h0);
        @(negedge clk); in_port[3] = 1'b0;
        wait_n(20);
        rd(2'd2, v); check("fall_only_fall", v, 32'h8);
        check("fall_irq", {31'd0, irq}, 32'd1);
        rd(2'd1, v); check("mask_read", v, 32'h8);
        wr(2'd2, 32'h8);

        // Clear held every cycle while a rising edge lands: set must win for one cycle
        wr(2'd3, 32'h3);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = 2'd2; writedata = 32'h8;
        in_port[3] = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (irq) seen = 1;
        end
        chipselect = 1'b0; write = 1'b0;
        check("set_wins", seen, 32'd1);
        rd(2'd2, v); check("set_wins_cleared", v, 32'h0);

`ifndef SWITCH_DEBOUNCE_EN
        // One-cycle pulse on bit 2 reaches DATA three cycles later
        @(negedge clk); in_port[2] = 1'b1;
        @(negedge clk); in_port[2] = 1'b0;
        @(negedge clk);
        rd(2'd0, v); check("nodeb_pulse", v, 32'h00C);
        wr(2'd2, 32'hFFFF_FFFF);
`endif

        // Randomized traffic against the model
        for (int it = 0; it < 1500; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    @(negedge clk);
                    in_port[$urandom_range(0, W - 1)] ^= 1'b1;
                    wait_n($urandom_range(1, 2 * D + 3));
                end
                4, 5: rd(2'($urandom_range(0, 3)), v);
                6, 7, 8: wr(2'($urandom_range(0, 3)), $urandom());
                default: if ($urandom_range(0, 19) == 0) do_reset();
            endcase
        end
        wait_n(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
